// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: receives MII-style bytes, strips preamble/SFD, writes frame
// bytes (FCS excluded) to a buffer, and checks the CRC-32 and the frame length.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   rx_dv, rx_er         PHY receive data valid / receive error
//   rx_data[7:0]         PHY receive byte, bit 0 first on the wire
//   wr_en, wr_addr[10:0], wr_data[7:0]
//                        frame buffer write port, one byte per strobe
//   frame_done           one-cycle pulse after each complete frame
//   frame_ok, frame_len[10:0], err_crc, err_len, err_phy
//                        status of the last frame, held until the next frame_done
module eth_rx_fcs_check #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rx_data,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [10:0] frame_len,
    output logic        err_crc,
    output logic        err_len,
    output logic        err_phy
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [11:0] MIN_L    = 12'(MIN_FRAME);
    localparam logic [11:0] MAX_L    = 12'(MAX_FRAME);
    localparam logic [11:0] WR_LIMIT = 12'(MAX_FRAME - 4);
    localparam logic [31:0] RESIDUE  = 32'hC704DD7B;

    state_t           state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [10:0]      cnt_q, cnt_d;
    logic [3:0][7:0]  dl_q, dl_d;
    logic             phy_q, phy_d;
    logic             wr_en_q, wr_en_d;
    logic [10:0]      wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_ok_q, frame_ok_d;
    logic [10:0]      frame_len_q, frame_len_d;
    logic             err_crc_q, err_crc_d;
    logic             err_len_q, err_len_d;
    logic             err_phy_q, err_phy_d;
    logic [10:0]      addr;

    // Byte-wise CRC-32, wire bit order (bit 0 first) into an MSB-first register.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
        return r;
    endfunction

    // Address of the oldest delay-line byte, written when the current byte arrives.
    assign addr = cnt_q - 11'd4;

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        dl_d         = dl_q;
        phy_d        = phy_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        frame_len_d  = frame_len_q;
        err_crc_d    = err_crc_q;
        err_len_d    = err_len_q;
        err_phy_d    = err_phy_q;
        case (state_q)
            IDLE: begin
                if (rx_dv)
                    state_d = (rx_data == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!rx_dv)
                    state_d = IDLE;
                else if (rx_data == 8'hD5) begin
                    state_d = DATA;
                    crc_d   = '1;
                    cnt_d   = '0;
                    phy_d   = 1'b0;
                end else if (rx_data != 8'h55)
                    state_d = DROP;
            end
            DATA: begin
                if (rx_dv) begin
                    crc_d = crc_next(crc_q, rx_data);
                    cnt_d = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
                    dl_d  = {dl_q[2:0], rx_data};
                    phy_d = phy_q | rx_er;
                    // The last four bytes stay in the delay line, so the FCS is never written.
                    if (cnt_q >= 11'd4 && {1'b0, addr} < WR_LIMIT) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr;
                        wr_data_d = dl_q[3];
                    end
                end else begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    frame_len_d  = cnt_q;
                    err_crc_d    = crc_q != RESIDUE;
                    err_len_d    = {1'b0, cnt_q} < MIN_L || {1'b0, cnt_q} > MAX_L;
                    err_phy_d    = phy_q;
                    frame_ok_d   = !(err_crc_d || err_len_d || phy_q);
                end
            end
            default: begin
                if (!rx_dv)
                    state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            crc_q        <= '1;
            cnt_q        <= '0;
            dl_q         <= '0;
            phy_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_len_q  <= '0;
            err_crc_q    <= 1'b0;
            err_len_q    <= 1'b0;
            err_phy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            dl_q         <= dl_d;
            phy_q        <= phy_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            frame_len_q  <= frame_len_d;
            err_crc_q    <= err_crc_d;
            err_len_q    <= err_len_d;
            err_phy_q    <= err_phy_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign frame_len  = frame_len_q;
    assign err_crc    = err_crc_q;
    assign err_len    = err_len_q;
    assign err_phy    = err_phy_q;
endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb_eth_rx_fcs_check: directed frames into two receivers (MIN_FRAME=13 and default).
module tb_eth_rx_fcs_check;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_dv = 1'b0;
    logic rx_er = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic [1:0]       wr_en_w, frame_done_w, frame_ok_w, err_crc_w, err_len_w, err_phy_w;
    logic [1:0][10:0] wr_addr_w, frame_len_w;
    logic [1:0][7:0]  wr_data_w;

    always #5 clk = ~clk;

    eth_rx_fcs_check #(.MIN_FRAME(13)) u13 (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
        .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0]),
        .frame_done(frame_done_w[0]), .frame_ok(frame_ok_w[0]), .frame_len(frame_len_w[0]),
        .err_crc(err_crc_w[0]), .err_len(err_len_w[0]), .err_phy(err_phy_w[0])
    );

    eth_rx_fcs_check udef (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
        .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1]),
        .frame_done(frame_done_w[1]), .frame_ok(frame_ok_w[1]), .frame_len(frame_len_w[1]),
        .err_crc(err_crc_w[1]), .err_len(err_len_w[1]), .err_phy(err_phy_w[1])
    );

    // plen: payload bytes before FCS; er: payload index carrying rx_er (-1 none);
    // d: 0 = MIN_FRAME 13 instance, 1 = default instance.
    typedef struct {
        int plen; int bad; int er; int d;
        int ok; int ecrc; int elen; int ephy; int nwr;
    } vec_t;

    vec_t vt[9];
    logic [7:0]  fbuf [0:2047];
    int          flen;
    logic [10:0] ca [2][0:8191];
    logic [7:0]  cd [2][0:8191];
    int          wn [2];
    int          dn [2];
    int          tests = 0;
    int          fails = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr_en_w[k] && wn[k] < 8192) begin
                ca[k][wn[k]] = wr_addr_w[k];
                cd[k][wn[k]] = wr_data_w[k];
                wn[k]++;
            end
            if (frame_done_w[k])
                dn[k]++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] b);
        @(negedge clk);
        rx_dv = dv;
        rx_er = er;
        rx_data = b;
    endtask

    // Reference CRC in reflected form, independent of the receiver's register layout.
    task automatic build(input int plen, input int bad);
        logic [31:0] c, fcs;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) begin
            fbuf[i] = (plen == 9) ? 8'(8'h31 + i) : 8'(i * 7 + 3);
            c = c ^ {24'h0, fbuf[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        fcs = (plen == 9) ? 32'hCBF43926 : ~c;
        for (int i = 0; i < 4; i++)
            fbuf[plen + i] = fcs[8*i +: 8];
        if (bad != 0)
            fbuf[plen + 3] = fbuf[plen + 3] ^ 8'h01;
        flen = plen + 4;
    endtask

    task automatic send(input int er);
        for (int i = 0; i < 7; i++)
            drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < flen; i++)
            drive(1'b1, i == er, fbuf[i]);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int w0, d0, bad;
        build(v.plen, v.bad);
        w0 = wn[v.d];
        d0 = dn[v.d];
        send(v.er);
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d done", n), dn[v.d] - d0, 1);
        chk($sformatf("v%0d frame_len", n), int'(frame_len_w[v.d]), v.plen + 4);
        chk($sformatf("v%0d frame_ok", n), int'(frame_ok_w[v.d]), v.ok);
        chk($sformatf("v%0d err_crc", n), int'(err_crc_w[v.d]), v.ecrc);
        chk($sformatf("v%0d err_len", n), int'(err_len_w[v.d]), v.elen);
        chk($sformatf("v%0d err_phy", n), int'(err_phy_w[v.d]), v.ephy);
        chk($sformatf("v%0d writes", n), wn[v.d] - w0, v.nwr);
        bad = 0;
        for (int i = 0; i < v.nwr && w0 + i < 8192; i++)
            if (int'(ca[v.d][w0 + i]) != i || cd[v.d][w0 + i] != fbuf[i])
                bad++;
        chk($sformatf("v%0d write contents", n), bad, 0);
    endtask

    task automatic chk_reset_state(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s[%0d] outputs", nm, k),
                int'({wr_en_w[k], wr_addr_w[k], wr_data_w[k], frame_done_w[k], frame_ok_w[k],
                      frame_len_w[k], err_crc_w[k], err_len_w[k], err_phy_w[k]}), 0);
        end
    endtask

    initial begin
        int w0, d0, w1, d1;
        vt[0] = '{9,    0, -1, 0, 1, 0, 0, 0, 9};
        vt[1] = '{9,    1, -1, 0, 0, 1, 0, 0, 9};
        vt[2] = '{9,    0,  2, 0, 0, 0, 0, 1, 9};
        vt[3] = '{56,   0, -1, 1, 0, 0, 1, 0, 56};
        vt[4] = '{60,   0, -1, 1, 1, 0, 0, 0, 60};
        vt[5] = '{8,    0, -1, 0, 0, 0, 1, 0, 8};
        vt[6] = '{1514, 0, -1, 1, 1, 0, 0, 0, 1514};
        vt[7] = '{1515, 0, -1, 1, 0, 0, 1, 0, 1514};
        vt[8] = '{56,   0, -1, 0, 1, 0, 0, 0, 56};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");

        for (int n = 0; n < 9; n++)
            run_vec(n, vt[n]);

        // Reset arrives with the 5th data byte: frame abandoned, nothing written.
        build(9, 0);
        w0 = wn[0];
        d0 = dn[0];
        for (int i = 0; i < 7; i++)
            drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, fbuf[i]);
        drive(1'b1, 1'b0, fbuf[4]);
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid-reset writes", wn[0] - w0, 0);
        chk("mid-reset done", dn[0] - d0, 0);
        chk_reset_state("mid-reset");
        run_vec(9, vt[0]);

        // Aborted preambles and a frame not starting with 0x55 produce nothing.
        w0 = wn[0]; d0 = dn[0]; w1 = wn[1]; d1 = dn[1];
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 8'h55);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++)
            drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h12);
        for (int i = 0; i < 20; i++)
            drive(1'b1, 1'b0, 8'(i + 1));
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++)
            drive(1'b1, 1'b0, 8'(i + 9));
        drive(1'b0, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        chk("abort writes u13", wn[0] - w0, 0);
        chk("abort done u13", dn[0] - d0, 0);
        chk("abort writes def", wn[1] - w1, 0);
        chk("abort done def", dn[1] - d1, 0);
        run_vec(10, vt[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/eth_rx_fcs_check.md
ETH_RX_FCS_CHECK -- requirements
Module: eth_rx_fcs_check

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 64: minimum legal frame length in bytes, destination MAC through FCS inclusive.
REQ-002 SHALL have parameter MAX_FRAME, default 1518: maximum legal frame length in bytes, FCS inclusive.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port rx_dv  input  1  PHY receive data valid, one byte per cycle.
REQ-006 SHALL have port rx_er  input  1  PHY receive error.
REQ-007 SHALL have port rx_data  input  8  PHY receive byte; bit 0 is the first bit on the wire.
REQ-008 SHALL have port wr_en  output  1  frame buffer write strobe.
REQ-009 SHALL have port wr_addr  output  11  frame buffer byte address.
REQ-010 SHALL have port wr_data  output  8  frame buffer byte.
REQ-011 SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.
REQ-012 SHALL have port frame_ok  output  1  last frame passed all checks.
REQ-013 SHALL have port frame_len  output  11  last frame length in bytes, FCS inclusive.
REQ-014 SHALL have port err_crc, err_len, err_phy  output  1 each  last frame error flags.

Function
REQ-015 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: rx_dv=1 and rx_data=0x55 SHALL go to PREAMBLE; rx_dv=1 with any other byte SHALL go to DROP.
REQ-017 PREAMBLE: 0x55 SHALL stay; 0xD5 SHALL go to DATA, load CRC register with 0xFFFFFFFF, clear byte count and error latches; any other byte SHALL go to DROP; rx_dv=0 SHALL go to IDLE.
REQ-018 DROP SHALL stay until rx_dv=0, then go to IDLE; no writes and no frame_done from DROP.
REQ-019 DATA, each rx_dv=1 cycle: SHALL update CRC-32 (poly 0x04C11DB7, bit-reversed byte input, MSB-first register), increment byte count (saturating at 2047), and shift the byte into a 4-byte delay line.
REQ-020 Once the delay line holds 4 bytes, each further DATA byte SHALL write the oldest byte: wr_en=1 the cycle after the sample, wr_addr = count-4, starting at 0; the 4 FCS bytes SHALL never be written.
REQ-021 Writes SHALL be suppressed when wr_addr would be >= MAX_FRAME-4.
REQ-022 rx_er=1 in DATA SHALL latch err_phy for the current frame; reception continues.
REQ-023 First rx_dv=0 in DATA: the following cycle SHALL pulse frame_done for one cycle and update frame_len, err_crc, err_len, err_phy and frame_ok; state returns to IDLE.
REQ-024 err_crc SHALL be 1 unless the CRC register after the final FCS byte equals 0xC704DD7B.
REQ-025 err_len SHALL be 1 if count < MIN_FRAME or count > MAX_FRAME.
REQ-026 frame_ok SHALL equal NOT(err_crc OR err_len OR err_phy).
REQ-027 frame_len, frame_ok and error flags SHALL hold their values until the next frame_done.
REQ-028 rx_dv=1 in the cycle of frame_done SHALL be treated as an IDLE-state sample.

Reset
REQ-029 reset SHALL force IDLE, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_ok=0, frame_len=0, all err flags 0, and clear the delay line and count.
REQ-030 reset mid-frame SHALL abort the frame with no frame_done and no further writes.

Verification
REQ-031 MIN_FRAME=13; 7x 0x55, 0xD5, ASCII "123456789", 0x26 0x39 0xF4 0xCB -> 9 writes at addr 0..8 with data 0x31..0x39; frame_done with frame_ok=1, frame_len=13, all err flags 0.
REQ-032 Same frame with last byte 0xCA -> 9 identical writes; err_crc=1, frame_ok=0.
REQ-033 Default params, 60-byte frame with correct FCS -> err_len=1, err_crc=0, frame_len=60, 56 writes.
REQ-034 REQ-031 frame with rx_er=1 on the 3rd data byte -> err_phy=1, frame_ok=0, err_crc=0.
REQ-035 reset on the 5th data byte, then the REQ-031 frame -> no frame_done for the first frame; second frame yields frame_ok=1, writes from addr 0.
REQ-036 Preamble then rx_dv=0 before 0xD5, or preamble followed by 0x12 -> no wr_en and no frame_done; next good frame accepted.
